// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the unified memory bus
// seen by the arbiter. The master modport is the arbiter's view and the slave
// modport is the view of the core plus memory model around it.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          stall;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core's fetch port
// and its load/store port. One transaction is in flight at a time; data wins
// ties unless fetch has already lost MAX_WAIT arbitrations in a row.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset_n,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t        r_state;
    state_t        w_nextState;
    owner_t        r_owner;
    logic [3:0]    r_starveCnt;
    logic          r_memWe;
    logic [AW-1:0] r_memAddr;
    logic [DW-1:0] r_memWdata;
    logic [DW-1:0] r_iRdata;
    logic [DW-1:0] r_dRdata;

    logic w_anyReq;
    logic w_bothReq;
    logic w_selFetch;
    logic w_memReq;
    logic w_iDone;
    logic w_dDone;

    assign w_anyReq   = bus.i_req | bus.d_req;
    assign w_bothReq  = bus.i_req & bus.d_req;
    assign w_selFetch = bus.i_req & (~bus.d_req | (r_starveCnt == MAX_CNT));

    // State register; reset drops straight to IDLE so mem_req falls at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE picks a requester, ISSUE waits for grant,
    // RESP waits for the response, DONE lasts exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq)       w_nextState = ISSUE;
            ISSUE:   if (bus.mem_gnt)    w_nextState = RESP;
            RESP:    if (bus.mem_rvalid) w_nextState = DONE;
            DONE:                        w_nextState = IDLE;
            default:                     w_nextState = IDLE;
        endcase
    end

    // Output decode: request only while issuing, done only for the owner.
    always_comb begin
        w_memReq = 1'b0;
        w_iDone  = 1'b0;
        w_dDone  = 1'b0;
        case (r_state)
            ISSUE: w_memReq = 1'b1;
            DONE: begin
                w_iDone = (r_owner == OWN_FETCH);
                w_dDone = (r_owner == OWN_DATA);
            end
            default: ;
        endcase
    end

    // Selection: latch owner and the request fields so later input changes
    // cannot disturb the transaction, and track fetch's consecutive losses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= OWN_DATA;
            r_starveCnt <= '0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else if (r_state == IDLE && w_anyReq) begin
            if (w_selFetch) begin
                r_owner     <= OWN_FETCH;
                r_starveCnt <= '0;
                r_memWe     <= 1'b0;
                r_memAddr   <= bus.i_addr;
                r_memWdata  <= '0;
            end else begin
                r_owner    <= OWN_DATA;
                r_memWe    <= bus.d_we;
                r_memAddr  <= bus.d_addr;
                r_memWdata <= bus.d_wdata;
                if (w_bothReq && r_starveCnt < MAX_CNT) begin
                    r_starveCnt <= r_starveCnt + 4'd1;
                end
            end
        end
    end

    // Response capture: only in RESP, and stores leave the load data alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iRdata <= '0;
            r_dRdata <= '0;
        end else if (r_state == RESP && bus.mem_rvalid) begin
            if (r_owner == OWN_FETCH) begin
                r_iRdata <= bus.mem_rdata;
            end else if (!r_memWe) begin
                r_dRdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = w_memReq;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.i_done    = w_iDone;
    assign bus.d_done    = w_dDone;
    assign bus.i_rdata   = r_iRdata;
    assign bus.d_rdata   = r_dRdata;
    assign bus.stall     = w_anyReq & ~(w_iDone | w_dDone);
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a memory responder with programmable grant and
// response delays, plus scoreboards of expected bus accesses and completions.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic        isData;
        logic [31:0] rdata;
    } doneExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } accExp_t;

    logic clk;
    logic reset_n;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    doneExp_t    expDone[$];
    accExp_t     expAcc[$];
    logic [31:0] memModel [logic [31:0]];

    int checkCount;
    int passCount;
    int doneCount;
    int reqCycles;
    int gntDelay;
    int rvDelay;
    int gntCount;
    int rvCount;
    bit respPending;
    logic [31:0] respData;
    accExp_t  curAcc;
    doneExp_t curDone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Queue one transaction's expectations and raise the matching request.
    task automatic applyStimulus(input bit isData, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata);
        accExp_t  a;
        doneExp_t e;
        a.we = we;
        a.addr = addr;
        a.wdata = wdata;
        expAcc.push_back(a);
        e.isData = isData;
        e.rdata = expRdata;
        expDone.push_back(e);
        if (isData) begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = addr;
        end
    endtask

    // Wait (bounded) until the completion count reaches target; returns cycles spent.
    task automatic waitDone(input int target, input int maxCycles, output int cycles);
        cycles = 0;
        while (doneCount < target && cycles < maxCycles) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        checkOutput("doneTimeout", 32'(doneCount), 32'(target));
    endtask

    // Memory responder and output monitor, both acting mid-cycle on the falling edge.
    initial begin
        gntCount = 0;
        rvCount = 0;
        respPending = 1'b0;
        respData = '0;
        doneCount = 0;
        reqCycles = 0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) begin
                doneCount++;
                checkOutput("doneBoth", 32'(bus.i_done & bus.d_done), 32'h0);
                if (expDone.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(bus.i_done | bus.d_done), 32'h0);
                end else begin
                    curDone = expDone.pop_front();
                    checkOutput("doneOwner", 32'(bus.d_done), 32'(curDone.isData));
                    checkOutput("doneRdata", curDone.isData ? bus.d_rdata : bus.i_rdata,
                                curDone.rdata);
                end
            end
            bus.mem_rvalid = 1'b0;
            if (respPending) begin
                if (rvCount == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = respData;
                    respPending = 1'b0;
                end else begin
                    rvCount--;
                end
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_req && reset_n) begin
                reqCycles++;
                if (expAcc.size() == 0) begin
                    checkOutput("unexpectedReq", 32'(bus.mem_req), 32'h0);
                end else begin
                    curAcc = expAcc[0];
                    checkOutput("memWe", 32'(bus.mem_we), 32'(curAcc.we));
                    checkOutput("memAddr", bus.mem_addr, curAcc.addr);
                    if (curAcc.we) checkOutput("memWdata", bus.mem_wdata, curAcc.wdata);
                    if (gntCount >= gntDelay) begin
                        bus.mem_gnt = 1'b1;
                        gntCount = 0;
                        void'(expAcc.pop_front());
                        if (curAcc.we) begin
                            memModel[curAcc.addr] = curAcc.wdata;
                            respData = 32'hFFFF_FFFF;
                        end else begin
                            respData = memModel.exists(curAcc.addr) ? memModel[curAcc.addr] : 32'h0;
                        end
                        respPending = 1'b1;
                        rvCount = rvDelay;
                    end else begin
                        gntCount++;
                    end
                end
            end else begin
                gntCount = 0;
            end
        end
    end

    // Directed sequence: reset state, load, store, fetch, contention, resets, input change.
    initial begin
        int cycles;
        int reqBefore;
        int stallCycles;
        int doneBefore;
        bit seenDone;
        checkCount = 0;
        passCount = 0;
        gntDelay = 0;
        rvDelay = 0;
        reset_n = 1'b1;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        memModel[32'h100] = 32'hDEADBEEF;
        memModel[32'h000] = 32'h00500093;
        memModel[32'h200] = 32'h0BADF00D;
        memModel[32'h300] = 32'hCAFE0001;
        memModel[32'h080] = 32'h55AA55AA;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstMemReq", 32'(bus.mem_req), 32'h0);
        checkOutput("rstMemWe", 32'(bus.mem_we), 32'h0);
        checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
        checkOutput("rstMemWdata", bus.mem_wdata, 32'h0);
        checkOutput("rstIDone", 32'(bus.i_done), 32'h0);
        checkOutput("rstDDone", 32'(bus.d_done), 32'h0);
        checkOutput("rstIRdata", bus.i_rdata, 32'h0);
        checkOutput("rstDRdata", bus.d_rdata, 32'h0);
        checkOutput("rstStall", 32'(bus.stall), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] single load");
        reqBefore = reqCycles;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        waitDone(doneCount + 1, 20, cycles);
        bus.d_req = 1'b0;
        checkOutput("loadLatency", 32'(cycles), 32'd4);
        checkOutput("loadReqCycles", 32'(reqCycles - reqBefore), 32'd1);

        $display("[TB] store with wait states");
        gntDelay = 3;
        rvDelay = 1;
        reqBefore = reqCycles;
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hDEADBEEF);
        waitDone(doneCount + 1, 30, cycles);
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        checkOutput("storeLatency", 32'(cycles), 32'd8);
        checkOutput("storeReqCycles", 32'(reqCycles - reqBefore), 32'd4);
        gntDelay = 0;
        rvDelay = 0;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678);
        waitDone(doneCount + 1, 20, cycles);
        bus.d_req = 1'b0;

        $display("[TB] fetch only");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h00500093);
        stallCycles = 0;
        seenDone = 1'b0;
        for (int k = 0; k < 20 && !seenDone; k++) begin
            #1;
            if (bus.i_done) begin
                seenDone = 1'b1;
                checkOutput("stallInDone", 32'(bus.stall), 32'h0);
            end else if (bus.stall) begin
                stallCycles++;
            end
            @(posedge clk);
            #2;
        end
        bus.i_req = 1'b0;
        checkOutput("fetchDoneSeen", 32'(seenDone), 32'h1);
        checkOutput("fetchStallCycles", 32'(stallCycles), 32'd3);

        $display("[TB] contention");
        for (int g = 0; g < 10; g++) begin
            accExp_t  a;
            doneExp_t e;
            a.we = 1'b0;
            a.wdata = '0;
            a.addr = (g % 5 == 4) ? 32'h300 : 32'h200;
            e.isData = (g % 5 != 4);
            e.rdata = (g % 5 == 4) ? 32'hCAFE0001 : 32'h0BADF00D;
            expAcc.push_back(a);
            expDone.push_back(e);
        end
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h200;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h300;
        waitDone(doneCount + 10, 200, cycles);
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("holdIRdata", bus.i_rdata, 32'hCAFE0001);
        checkOutput("holdDRdata", bus.d_rdata, 32'h0BADF00D);

        $display("[TB] reset during ISSUE");
        gntDelay = 100;
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 32'h55AA55AA);
        @(posedge clk);
        #2;
        checkOutput("issueReqHigh", 32'(bus.mem_req), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncReqDrop", 32'(bus.mem_req), 32'h0);
        bus.d_req = 1'b0;
        expDone.delete();
        expAcc.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        gntDelay = 0;
        @(posedge clk);
        #2;

        $display("[TB] reset during RESP with late response");
        rvDelay = 4;
        doneBefore = doneCount;
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 32'h55AA55AA);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("respRstMemReq", 32'(bus.mem_req), 32'h0);
        checkOutput("respRstDDone", 32'(bus.d_done), 32'h0);
        bus.d_req = 1'b0;
        expDone.delete();
        expAcc.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rvDelay = 0;
        checkOutput("staleDRdata", bus.d_rdata, 32'h0);
        checkOutput("staleIRdata", bus.i_rdata, 32'h0);
        checkOutput("staleMemReq", 32'(bus.mem_req), 32'h0);
        checkOutput("staleStall", 32'(bus.stall), 32'h0);
        checkOutput("staleNoDone", 32'(doneCount), 32'(doneBefore));

        $display("[TB] input change after latch");
        gntDelay = 2;
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        @(posedge clk);
        #2;
        bus.d_addr = 32'h200;
        bus.d_we = 1'b1;
        bus.d_wdata = 32'h0F0F0F0F;
        waitDone(doneCount + 1, 20, cycles);
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        gntDelay = 0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("finalDRdata", bus.d_rdata, 32'hDEADBEEF);
        checkOutput("finalIRdata", bus.i_rdata, 32'h0);
        checkOutput("expDoneLeft", 32'(expDone.size()), 32'h0);
        checkOutput("expAccLeft", 32'(expAcc.size()), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global guard so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
